ternary_serial_comparator: RTL and testbench



---
 rtl/ternary_serial_comparator.sv | 116 +++++++++++
 tb/tb_ternary_serial_comparator.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ternary_serial_comparator.sv
// Word-level magnitude sequencer: folds per-trit eq/gt/lt flags (MS trit first) into the
// relation of two N_TRITS-digit ternary words, with start, trit and result handshakes.
module ternary_serial_comparator #(
   parameter int unsigned N_TRITS = 6,
   parameter int unsigned IDX_W   = $clog2(N_TRITS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       cmp_eq,
   input  logic [1:0]       cmp_gt,
   input  logic [1:0]       cmp_lt,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [IDX_W-1:0] trit_idx,
   output logic             busy,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [1:0]       res_eq,
   output logic [1:0]       res_gt,
   output logic [1:0]       res_lt,
   output logic             err
);

   localparam logic [1:0]       FlagT   = 2'b10;
   localparam logic [1:0]       FlagF   = 2'b00;
   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_TRITS - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;
   typedef enum logic [1:0] {RelEq, RelGt, RelLt} rel_e;

   state_e state;
   rel_e   rel, rel_n;
   logic   decided, decided_n, err_n, legal;

   // Outcome of accepting the current flag set; once decided, later trits are only counted.
   always_comb begin
      legal     = (cmp_eq == FlagT && cmp_gt == FlagF && cmp_lt == FlagF) ||
                  (cmp_eq == FlagF && cmp_gt == FlagT && cmp_lt == FlagF) ||
                  (cmp_eq == FlagF && cmp_gt == FlagF && cmp_lt == FlagT);
      rel_n     = rel;
      decided_n = decided;
      err_n     = err;
      if (!legal) begin
         err_n = 1'b1;
      end else if (!decided) begin
         if (cmp_gt == FlagT) begin
            rel_n     = RelGt;
            decided_n = 1'b1;
         end else if (cmp_lt == FlagT) begin
            rel_n     = RelLt;
            decided_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= StIdle;
         rel       <= RelEq;
         decided   <= 1'b0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         res_valid <= 1'b0;
         trit_idx  <= '0;
         res_eq    <= FlagF;
         res_gt    <= FlagF;
         res_lt    <= FlagF;
         err       <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (start) begin
                  state    <= StRun;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  trit_idx <= '0;
                  decided  <= 1'b0;
                  rel      <= RelEq;
                  err      <= 1'b0;
                  res_eq   <= FlagF;
                  res_gt   <= FlagF;
                  res_lt   <= FlagF;
               end
            end
            StRun: begin
               if (in_valid) begin
                  rel      <= rel_n;
                  decided  <= decided_n;
                  err      <= err_n;
                  trit_idx <= trit_idx + IDX_W'(1);
                  if (trit_idx == LastIdx) begin
                     state     <= StDone;
                     in_ready  <= 1'b0;
                     res_valid <= 1'b1;
                     res_eq    <= (!err_n && rel_n == RelEq) ? FlagT : FlagF;
                     res_gt    <= (!err_n && rel_n == RelGt) ? FlagT : FlagF;
                     res_lt    <= (!err_n && rel_n == RelLt) ? FlagT : FlagF;
                  end
               end
            end
            StDone: begin
               // res_* and err stay as the last word's outcome until the next start.
               if (res_ready) begin
                  state     <= StIdle;
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  trit_idx  <= '0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ternary_serial_comparator.sv
// Bench for ternary_serial_comparator: directed and random words checked against an
// integer-valued reference of the two ternary operands.
module tb_ternary_serial_comparator;

   localparam int N = 4;
   localparam int W = $clog2(N + 1);

   logic         clk = 1'b0;
   logic         rst_n, start, in_valid, res_ready;
   logic [1:0]   cmp_eq, cmp_gt, cmp_lt;
   logic         in_ready, busy, res_valid, err;
   logic [W-1:0] trit_idx;
   logic [1:0]   res_eq, res_gt, res_lt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ternary_serial_comparator #(.N_TRITS(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt),
      .in_valid(in_valid), .in_ready(in_ready), .trit_idx(trit_idx), .busy(busy),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_eq(res_eq), .res_gt(res_gt), .res_lt(res_lt), .err(err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, " in_ready"}, 32'(in_ready), 0);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " res_valid"}, 32'(res_valid), 0);
      check({tag, " trit_idx"}, 32'(trit_idx), 0);
   endtask

   // Reference: word relation from the integer values of the operands.
   task automatic run_word(input int a[N], input int b[N], input int bad_pos, input int bad_kind,
                           input bit toggle, input int hold, input bit both);
      int va, vb, acc, guard;
      logic [1:0] e_eq, e_gt, e_lt;
      bit e_err;
      va = 0;
      vb = 0;
      for (int i = 0; i < N; i++) begin
         va = va * 3 + a[i];
         vb = vb * 3 + b[i];
      end
      e_err = (bad_pos >= 0);
      e_eq  = (!e_err && va == vb) ? 2'b10 : 2'b00;
      e_gt  = (!e_err && va >  vb) ? 2'b10 : 2'b00;
      e_lt  = (!e_err && va <  vb) ? 2'b10 : 2'b00;

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("run busy", 32'(busy), 1);
      check("run in_ready", 32'(in_ready), 1);
      check("run trit_idx0", 32'(trit_idx), 0);
      check("run res_eq cleared", 32'(res_eq), 0);

      acc = 0;
      guard = 0;
      while (acc < N && guard < 4 * N) begin
         in_valid = toggle ? ((guard % 2) == 0) : 1'b1;
         cmp_eq = (a[acc] == b[acc]) ? 2'b10 : 2'b00;
         cmp_gt = (a[acc] >  b[acc]) ? 2'b10 : 2'b00;
         cmp_lt = (a[acc] <  b[acc]) ? 2'b10 : 2'b00;
         if (acc == bad_pos) begin
            if (bad_kind == 1) begin
               cmp_eq = 2'b10;
               cmp_gt = 2'b10;
            end else begin
               cmp_lt = 2'b11;
            end
         end
         start = (acc == 1);
         @(negedge clk);
         if (in_valid) acc++;
         guard++;
         check("trit_idx", 32'(trit_idx), 32'(acc));
         check("in_ready", 32'(in_ready), (acc < N) ? 1 : 0);
      end
      if (acc < N) check("accept timeout", 32'(acc), N);
      start    = 1'b0;
      in_valid = 1'b0;

      for (int h = 0; h <= hold; h++) begin
         check("done res_valid", 32'(res_valid), 1);
         check("done busy", 32'(busy), 1);
         check("done trit_idx", 32'(trit_idx), N);
         check("res_eq", 32'(res_eq), 32'(e_eq));
         check("res_gt", 32'(res_gt), 32'(e_gt));
         check("res_lt", 32'(res_lt), 32'(e_lt));
         check("err", 32'(err), 32'(e_err));
         if (h < hold) @(negedge clk);
      end

      res_ready = 1'b1;
      start     = both;
      @(negedge clk);
      res_ready = 1'b0;
      start     = 1'b0;
      check_idle("after handshake");
      check("held res_gt", 32'(res_gt), 32'(e_gt));
      check("held err", 32'(err), 32'(e_err));
      if (both) begin
         @(negedge clk);
         check("start with res_ready ignored", 32'(busy), 0);
      end
   endtask

   int a[N], b[N];
   int pre;

   initial begin
      rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; res_ready = 1'b0;
      cmp_eq = 2'b10; cmp_gt = 2'b00; cmp_lt = 2'b00;
      repeat (2) @(negedge clk);
      check_idle("reset");
      check("reset err", 32'(err), 0);
      check("reset res", 32'({res_eq, res_gt, res_lt}), 0);
      rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      @(negedge clk);
      check("idle ignores in_valid", 32'(trit_idx), 0);
      in_valid = 1'b0;

      a = '{1, 2, 0, 1}; b = '{1, 2, 0, 1};
      run_word(a, b, -1, 0, 1'b0, 0, 1'b0);
      a = '{1, 2, 1, 0}; b = '{1, 2, 0, 2};
      run_word(a, b, -1, 0, 1'b0, 1, 1'b0);
      a = '{0, 2, 2, 2}; b = '{1, 0, 0, 0};
      run_word(a, b, -1, 0, 1'b1, 3, 1'b1);
      a = '{1, 2, 0, 1}; b = '{1, 1, 0, 1};
      run_word(a, b, 1, 1, 1'b0, 0, 1'b0);
      run_word(a, b, 1, 2, 1'b0, 0, 1'b0);

      // Reset mid-word after two accepts, then a fresh word.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1;
      cmp_eq = 2'b00; cmp_gt = 2'b10; cmp_lt = 2'b00;
      repeat (2) @(negedge clk);
      check("mid trit_idx", 32'(trit_idx), 2);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle("mid reset");
      rst_n = 1'b1; in_valid = 1'b0;
      a = '{0, 1, 2, 0}; b = '{0, 1, 2, 1};
      run_word(a, b, -1, 0, 1'b0, 0, 1'b0);

      for (int k = 0; k < 24; k++) begin
         pre = $urandom_range(0, N);
         for (int i = 0; i < N; i++) begin
            a[i] = $urandom_range(0, 2);
            b[i] = (i < pre) ? a[i] : $urandom_range(0, 2);
         end
         run_word(a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : -1,
                  $urandom_range(1, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
